// File: rtl/multicycle_seq.sv
// multicycle_seq: multicycle CPU control sequencer with memory-ack timeout and FAULT state.
// Optional instruction counter port instr_cnt is enabled by defining MULTICYCLE_SEQ_INSTR_CNT_EN.
module multicycle_seq #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  opcode,
   input  logic        z,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        ir_ld,
   output logic        pc_ld,
   output logic        pc_src,
   output logic        reg_src,
   output logic        alu_src,
   output logic        wr_src,
   output logic        reg_wr_en,
   output logic [2:0]  alu_opcode,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        illegal,
   output logic        fault,
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
   output logic [31:0] instr_cnt,
`endif
   output logic [2:0]  state
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE, EXEC, MEM, WB, FAULT} state_t;
   typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_ILL} cls_t;
   typedef struct packed {
      cls_t       cls;
      logic [2:0] alu;
      logic       alu_src;
      logic       reg_src;
   } dec_t;
   localparam int CW = $clog2(MEM_TIMEOUT + 2);

   function automatic dec_t dec(input logic [4:0] op);
      case (op)
         5'b00010: dec = '{C_R, 3'd0, 1'b0, 1'b1};
         5'b00011: dec = '{C_R, 3'd1, 1'b0, 1'b1};
         5'b00100: dec = '{C_R, 3'd2, 1'b0, 1'b1};
         5'b00101: dec = '{C_R, 3'd3, 1'b0, 1'b1};
         5'b00110: dec = '{C_R, 3'd4, 1'b0, 1'b1};
         5'b01000: dec = '{C_R, 3'd5, 1'b0, 1'b1};
         5'b01001: dec = '{C_R, 3'd6, 1'b0, 1'b1};
         5'b01010: dec = '{C_R, 3'd7, 1'b0, 1'b1};
         5'b10010: dec = '{C_I, 3'd0, 1'b1, 1'b1};
         5'b10100: dec = '{C_I, 3'd2, 1'b1, 1'b1};
         5'b10101: dec = '{C_I, 3'd3, 1'b1, 1'b1};
         5'b10110: dec = '{C_I, 3'd4, 1'b1, 1'b1};
         5'b11100: dec = '{C_LW, 3'd0, 1'b1, 1'b0};
         5'b11101: dec = '{C_SW, 3'd0, 1'b1, 1'b0};
         5'b11110: dec = '{C_BEQ, 3'd1, 1'b0, 1'b0};
         5'b11111: dec = '{C_BNE, 3'd1, 1'b0, 1'b0};
         default:  dec = '{C_ILL, 3'd0, 1'b0, 1'b0};
      endcase
   endfunction

   state_t         state_q, state_d;
   logic [4:0]     op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           waiting;
   dec_t           dn, dq;
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
   logic [31:0]    icnt_q, icnt_d;
   assign instr_cnt = icnt_q;
`endif

   assign dn    = dec(opcode);
   assign dq    = dec(op_q);
   assign state = state_q;
   assign fault = state_q == FAULT;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      imem_req   = 1'b0;
      ir_ld      = 1'b0;
      pc_ld      = 1'b0;
      pc_src     = 1'b0;
      wr_src     = 1'b0;
      reg_wr_en  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            ir_ld    = imem_ack;
            state_d  = imem_ack ? DECODE : FETCH;
         end
         DECODE: begin
            op_d    = opcode;
            illegal = dn.cls == C_ILL;
            pc_ld   = dn.cls == C_ILL;
            state_d = dn.cls == C_ILL ? FETCH : EXEC;
         end
         EXEC: begin
            pc_ld   = dq.cls == C_BEQ || dq.cls == C_BNE;
            pc_src  = dq.cls == C_BEQ ? z : (dq.cls == C_BNE && !z);
            state_d = pc_ld ? FETCH : (dq.cls == C_LW || dq.cls == C_SW) ? MEM : WB;
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dq.cls == C_SW;
            pc_ld    = dmem_ack && dq.cls == C_SW;
            state_d  = !dmem_ack ? MEM : dq.cls == C_SW ? FETCH : WB;
         end
         WB: begin
            reg_wr_en = 1'b1;
            wr_src    = dq.cls != C_LW;
            pc_ld     = 1'b1;
            state_d   = FETCH;
         end
         FAULT: state_d = FAULT;
         default: state_d = FETCH;
      endcase
      // an ack in the cycle the count would hit the limit takes priority
      waiting = (state_q == FETCH && !imem_ack) || (state_q == MEM && !dmem_ack);
      if (MEM_TIMEOUT != 0 && waiting && cnt_q + 1'b1 == CW'(MEM_TIMEOUT))
         state_d = FAULT;
      cnt_d = state_d != state_q ? '0 : cnt_q + CW'(waiting);
      {alu_opcode, alu_src, reg_src} = (state_q == EXEC || state_q == MEM || state_q == WB) ?
                                       {dq.alu, dq.alu_src, dq.reg_src} : 5'b0;
      if (rst)
         {imem_req, ir_ld, pc_ld, pc_src, wr_src, reg_wr_en, dmem_req, dmem_we, illegal} = '0;
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
      icnt_d = icnt_q + 32'(pc_ld);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
         icnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
         icnt_q  <= icnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: scoreboard bench for multicycle_seq; per-cycle expected outputs are queued
// as stimulus is driven and compared at the following falling edge.
module tb_multicycle_seq;
   localparam logic [4:0] LW = 5'b11100, SW = 5'b11101, BEQ = 5'b11110, BNE = 5'b11111;
   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] opcode = '0;
   logic z = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
   logic imem_req, ir_ld, pc_ld, pc_src, reg_src, alu_src, wr_src, reg_wr_en;
   logic [2:0] alu_opcode, state;
   logic dmem_req, dmem_we, illegal, fault;
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
   logic [31:0] instr_cnt;
`endif

   multicycle_seq #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .z(z), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_src(pc_src), .reg_src(reg_src),
      .alu_src(alu_src), .wr_src(wr_src), .reg_wr_en(reg_wr_en), .alu_opcode(alu_opcode),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .illegal(illegal), .fault(fault),
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
      .instr_cnt(instr_cnt),
`endif
      .state(state));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic imem_req, ir_ld, pc_ld, pc_src, reg_src, alu_src, wr_src, reg_wr_en;
      logic [2:0] alu;
      logic dmem_req, dmem_we, illegal, fault;
   } exp_t;
   typedef struct {
      exp_t  e;
      logic  r;
      string tag;
   } item_t;

   item_t sb[$];
   int total = 0, bad = 0;
   logic [31:0] cnt_m = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {legal, alu_src, reg_src, alu_opcode}
   function automatic logic [5:0] amap(input logic [4:0] op);
      case (op)
         5'b00010: amap = {3'b101, 3'd0};
         5'b00011: amap = {3'b101, 3'd1};
         5'b00100: amap = {3'b101, 3'd2};
         5'b00101: amap = {3'b101, 3'd3};
         5'b00110: amap = {3'b101, 3'd4};
         5'b01000: amap = {3'b101, 3'd5};
         5'b01001: amap = {3'b101, 3'd6};
         5'b01010: amap = {3'b101, 3'd7};
         5'b10010: amap = {3'b111, 3'd0};
         5'b10100: amap = {3'b111, 3'd2};
         5'b10101: amap = {3'b111, 3'd3};
         5'b10110: amap = {3'b111, 3'd4};
         LW, SW:   amap = {3'b110, 3'd0};
         BEQ, BNE: amap = {3'b100, 3'd1};
         default:  amap = 6'b0;
      endcase
   endfunction

   function automatic exp_t b(input logic [2:0] st, input logic [4:0] op);
      logic [5:0] m;
      m = amap(op);
      b = '0;
      b.st = st;
      b.imem_req = st == 3'd0;
      if (st == 3'd2 || st == 3'd3 || st == 3'd4) {b.alu_src, b.reg_src, b.alu} = m[4:0];
      b.dmem_req = st == 3'd3;
      b.dmem_we = st == 3'd3 && op == SW;
      b.fault = st == 3'd5;
   endfunction

   task automatic drive(input logic [4:0] op, input logic ia, input logic da, input logic zz,
                        input logic r, input exp_t e, input string tag);
      @(posedge clk);
      #1;
      opcode = op; imem_ack = ia; dmem_ack = da; z = zz; rst = r;
      sb.push_back('{e, r, tag});
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         item_t it;
         exp_t g;
         it = sb.pop_front();
         g = {state, imem_req, ir_ld, pc_ld, pc_src, reg_src, alu_src, wr_src, reg_wr_en,
              alu_opcode, dmem_req, dmem_we, illegal, fault};
         chk(it.tag, 32'(g), 32'(it.e));
`ifdef MULTICYCLE_SEQ_INSTR_CNT_EN
         chk({it.tag, "_cnt"}, instr_cnt, cnt_m);
`endif
         cnt_m = it.r ? '0 : cnt_m + 32'(it.e.pc_ld);
      end
   end

   // one instruction; opcode is scrambled after DECODE so later states must use the latched copy
   task automatic run(input logic [4:0] op, input int di, input int dd, input logic zz,
                      input logic nz, input logic rwb);
      exp_t e;
      logic [5:0] m;
      logic [4:0] xo;
      m = amap(op);
      xo = op ^ 5'h1f;
      for (int i = 0; i < di; i++) drive(op, 1'b0, nz, zz, 1'b0, b(3'd0, op), "fetch_wait");
      e = b(3'd0, op); e.ir_ld = 1'b1;
      drive(op, 1'b1, nz, zz, 1'b0, e, "fetch");
      e = b(3'd1, op);
      if (!m[5]) begin
         e.illegal = 1'b1; e.pc_ld = 1'b1;
         drive(op, nz, nz, zz, 1'b0, e, "decode_ill");
         return;
      end
      drive(op, nz, nz, zz, 1'b0, e, "decode");
      e = b(3'd2, op);
      if (op == BEQ || op == BNE) begin
         e.pc_ld = 1'b1; e.pc_src = op == BEQ ? zz : !zz;
         drive(xo, nz, nz, zz, 1'b0, e, "exec_br");
         return;
      end
      drive(xo, nz, nz, zz, 1'b0, e, "exec");
      if (op == LW || op == SW) begin
         for (int i = 0; i < dd; i++) drive(xo, nz, 1'b0, zz, 1'b0, b(3'd3, op), "mem_wait");
         e = b(3'd3, op); e.pc_ld = op == SW;
         drive(xo, nz, 1'b1, zz, 1'b0, e, "mem");
         if (op == SW) return;
      end
      e = b(3'd4, op);
      if (rwb) begin
         drive(xo, nz, nz, zz, 1'b1, e, "wb_rst");
         return;
      end
      e.reg_wr_en = 1'b1; e.wr_src = op != LW; e.pc_ld = 1'b1;
      drive(xo, nz, nz, zz, 1'b0, e, "wb");
   endtask

   logic [4:0] ops [12] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
                            5'b01001, 5'b01010, 5'b10010, 5'b10100, 5'b10101, 5'b10110};
   logic [4:0] bad_ops [4] = '{5'b00000, 5'b00111, 5'b11011, 5'b10011};

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      run(5'b00010, 1, 0, 1'b0, 1'b0, 1'b0);
      foreach (ops[i]) run(ops[i], 0, 0, 1'b0, 1'b1, 1'b0);
      run(LW, 0, 3, 1'b0, 1'b0, 1'b0);
      run(SW, 0, 0, 1'b0, 1'b1, 1'b0);
      run(BEQ, 0, 0, 1'b1, 1'b0, 1'b0);
      run(BEQ, 0, 0, 1'b0, 1'b0, 1'b0);
      run(BNE, 0, 0, 1'b1, 1'b0, 1'b0);
      run(BNE, 0, 0, 1'b0, 1'b1, 1'b0);
      foreach (bad_ops[i]) run(bad_ops[i], 0, 0, 1'b0, 1'b1, 1'b0);
      run(LW, 14, 14, 1'b0, 1'b0, 1'b0);
      run(5'b00010, 0, 0, 1'b0, 1'b0, 1'b1);
      run(5'b10010, 0, 0, 1'b0, 1'b0, 1'b0);
      e = b(3'd0, SW); e.ir_ld = 1'b1;
      drive(SW, 1'b1, 1'b0, 1'b0, 1'b0, e, "to_fetch");
      drive(SW, 1'b0, 1'b0, 1'b0, 1'b0, b(3'd1, SW), "to_decode");
      drive(SW, 1'b0, 1'b0, 1'b0, 1'b0, b(3'd2, SW), "to_exec");
      for (int i = 0; i < 15; i++) drive(SW, 1'b0, 1'b0, 1'b0, 1'b0, b(3'd3, SW), "to_mem");
      for (int i = 0; i < 3; i++) drive(SW, 1'b1, 1'b1, 1'b0, 1'b0, b(3'd5, SW), "fault_hold");
      drive(SW, 1'b1, 1'b1, 1'b0, 1'b1, b(3'd5, SW), "fault_rst");
      drive(SW, 1'b0, 1'b0, 1'b0, 1'b0, b(3'd0, SW), "post_rst");
      run(5'b01010, 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
